// File: rtl/cache_miss_ctrl.sv
// Miss-handling controller: picks a victim way, writes back a dirty victim, fetches the line,
// fills the arrays and commits the touch to the PLRU. Option: MISS_CTRL_INVALID_FIRST_EN.
module cache_miss_ctrl #(
  parameter int unsigned WAYS    = 4,
  parameter int unsigned S_INDEX = 4,
  parameter int unsigned TAG_W   = 23,
  parameter int unsigned LINE_W  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_req,
  input  logic [S_INDEX-1:0]     miss_set,
  input  logic [TAG_W-1:0]       miss_tag,
  output logic                   miss_done,
  input  logic [WAYS-1:0]        way_valid,
  input  logic [WAYS-1:0]        way_dirty,
  input  logic [WAYS*TAG_W-1:0]  way_tags,
  input  logic [WAYS*LINE_W-1:0] way_data,
  input  logic [WAYS-1:0]        evict_candidate,
  output logic [S_INDEX-1:0]     repl_set,
  output logic                   repl_web,
  output logic [WAYS-1:0]        repl_touch,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic                   mem_ready,
  input  logic [LINE_W-1:0]      mem_rdata,
  output logic [WAYS-1:0]        fill_we,
  output logic [TAG_W-1:0]       fill_tag,
  output logic [LINE_W-1:0]      fill_data
);

  localparam int unsigned OFFSET_W = 32 - TAG_W - S_INDEX;
  localparam int unsigned WAY_W    = $clog2(WAYS);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StWriteback,
    StFill,
    StCommit,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [S_INDEX-1:0]  set_q;
  logic [TAG_W-1:0]    tag_q;
  logic [WAYS-1:0]     victim_q;
  logic [TAG_W-1:0]    wb_tag_q;
  logic [LINE_W-1:0]   wb_data_q;
  logic [LINE_W-1:0]   line_q;

  logic [WAY_W-1:0]    cand_idx;
  logic [WAY_W-1:0]    victim_idx;
  logic [WAYS-1:0]     victim_oh;
  logic                victim_dirty;

  // Lowest set bit of the candidate; an all-zero candidate falls back to way 0.
  always_comb begin
    cand_idx = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (evict_candidate[i]) cand_idx = WAY_W'(i);
    end
  end

`ifdef MISS_CTRL_INVALID_FIRST_EN
  logic [WAY_W-1:0] inv_idx;

  always_comb begin
    inv_idx = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!way_valid[i]) inv_idx = WAY_W'(i);
    end
  end

  assign victim_idx = (&way_valid) ? cand_idx : inv_idx;
`else
  assign victim_idx = cand_idx;
`endif

  assign victim_oh    = {{(WAYS-1){1'b0}}, 1'b1} << victim_idx;
  assign victim_dirty = way_valid[victim_idx] & way_dirty[victim_idx];
  assign repl_set     = set_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      set_q     <= '0;
      tag_q     <= '0;
      victim_q  <= '0;
      wb_tag_q  <= '0;
      wb_data_q <= '0;
      line_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && miss_req) begin
        set_q <= miss_set;
        tag_q <= miss_tag;
      end
      // Victim tag/data only matter on the writeback path, so latching them every time is safe.
      if (state_q == StSelect) begin
        victim_q  <= victim_oh;
        wb_tag_q  <= way_tags[victim_idx*TAG_W +: TAG_W];
        wb_data_q <= way_data[victim_idx*LINE_W +: LINE_W];
      end
      if (state_q == StFill && mem_ready) line_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    miss_done  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_we    = '0;
    fill_tag   = '0;
    fill_data  = '0;
    repl_web   = 1'b1;
    repl_touch = '0;
    case (state_q)
      StIdle: begin
        if (miss_req) state_d = StSelect;
      end
      StSelect: begin
        state_d = victim_dirty ? StWriteback : StFill;
      end
      StWriteback: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wb_tag_q, set_q, {OFFSET_W{1'b0}}};
        mem_wdata = wb_data_q;
        if (mem_ready) state_d = StFill;
      end
      StFill: begin
        mem_req  = 1'b1;
        mem_addr = {tag_q, set_q, {OFFSET_W{1'b0}}};
        if (mem_ready) state_d = StCommit;
      end
      StCommit: begin
        fill_we    = victim_q;
        fill_tag   = tag_q;
        fill_data  = line_q;
        repl_web   = 1'b0;
        repl_touch = victim_q;
        state_d    = StDone;
      end
      StDone: begin
        miss_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: expected memory transfers, fills and done cycles are
// queued when a miss is issued and popped as the controller produces them.
module tb_cache_miss_ctrl;

  localparam int W  = 4;
  localparam int SI = 4;
  localparam int TW = 23;
  localparam int LW = 256;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            miss_req = 1'b0;
  logic [SI-1:0]   miss_set = '0;
  logic [TW-1:0]   miss_tag = '0;
  logic            miss_done;
  logic [W-1:0]    way_valid = '0;
  logic [W-1:0]    way_dirty = '0;
  logic [W*TW-1:0] way_tags = '0;
  logic [W*LW-1:0] way_data = '0;
  logic [W-1:0]    evict_candidate = '0;
  logic [SI-1:0]   repl_set;
  logic            repl_web;
  logic [W-1:0]    repl_touch;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [LW-1:0]   mem_wdata;
  logic            mem_ready = 1'b0;
  logic [LW-1:0]   mem_rdata = '0;
  logic [W-1:0]    fill_we;
  logic [TW-1:0]   fill_tag;
  logic [LW-1:0]   fill_data;

  cache_miss_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .miss_req        (miss_req),
    .miss_set        (miss_set),
    .miss_tag        (miss_tag),
    .miss_done       (miss_done),
    .way_valid       (way_valid),
    .way_dirty       (way_dirty),
    .way_tags        (way_tags),
    .way_data        (way_data),
    .evict_candidate (evict_candidate),
    .repl_set        (repl_set),
    .repl_web        (repl_web),
    .repl_touch      (repl_touch),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .fill_we         (fill_we),
    .fill_tag        (fill_tag),
    .fill_data       (fill_data)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [LW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [W-1:0]  we;
    logic [TW-1:0] tag;
    logic [LW-1:0] data;
    logic [SI-1:0] set;
    int            cyc;
  } fill_exp_t;

  mem_exp_t  mem_q[$];
  fill_exp_t fill_q[$];
  int        done_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int wb_wait = 0;
  int fill_wait = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] way_line(int i);
    logic [31:0] w;
    w = 32'hCAFE_0000 + 32'(i);
    return {8{w}};
  endfunction

  function automatic logic [LW-1:0] rdata_for(logic [31:0] addr);
    logic [31:0] w;
    w = addr ^ 32'h5A5A_5A5A;
    return {4{w, ~w}};
  endfunction

  function automatic int model_victim(logic [W-1:0] valid, logic [W-1:0] cand);
`ifdef MISS_CTRL_INVALID_FIRST_EN
    for (int i = 0; i < W; i++) if (!valid[i]) return i;
`endif
    for (int i = 0; i < W; i++) if (cand[i]) return i;
    return 0;
  endfunction

  // Queue everything one miss should produce; returns the cycle count at which done is due.
  function automatic int push_expect(int start, logic [SI-1:0] set, logic [TW-1:0] tag);
    int        v;
    bit        dirty;
    int        done_at;
    mem_exp_t  me;
    fill_exp_t fe;
    v     = model_victim(way_valid, evict_candidate);
    dirty = way_valid[v] && way_dirty[v];
    if (dirty) begin
      me.we    = 1'b1;
      me.addr  = {way_tags[v*TW +: TW], set, 5'h0};
      me.wdata = way_data[v*LW +: LW];
      mem_q.push_back(me);
    end
    me.we    = 1'b0;
    me.addr  = {tag, set, 5'h0};
    me.wdata = '0;
    mem_q.push_back(me);
    done_at  = start + 3 + (dirty ? 1 + wb_wait : 0) + fill_wait;
    fe.we    = W'(1) << v;
    fe.tag   = tag;
    fe.data  = rdata_for(me.addr);
    fe.set   = set;
    fe.cyc   = done_at - 1;
    fill_q.push_back(fe);
    done_q.push_back(done_at);
    return done_at;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: mem_ready after the configured number of wait cycles per request phase.
  initial begin
    bit acc;
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      acc = mem_req && mem_ready;
      @(posedge clk);
      #1;
      if (!mem_req || acc) wcnt = 0;
      if (mem_req && wcnt >= (mem_we ? wb_wait : fill_wait)) begin
        mem_ready = 1'b1;
        mem_rdata = rdata_for(mem_addr);
      end else begin
        mem_ready = 1'b0;
        if (mem_req) wcnt++;
      end
    end
  end

  // Output monitor.
  initial begin
    bit            pend;
    logic [31:0]   p_addr;
    logic          p_we;
    logic [LW-1:0] p_wdata;
    mem_exp_t      me;
    fill_exp_t     fe;
    int            d;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend && mem_req) begin
          check("mem_addr_stable", mem_addr, p_addr);
          check("mem_we_stable", mem_we, p_we);
          check("mem_wdata_stable", mem_wdata, p_wdata);
        end
        if (mem_req && mem_ready) begin
          check("mem_xfer_expected", mem_q.size() > 0, 1'b1);
          if (mem_q.size() > 0) begin
            me = mem_q.pop_front();
            check("mem_we", mem_we, me.we);
            check("mem_addr", mem_addr, me.addr);
            if (me.we) check("mem_wdata", mem_wdata, me.wdata);
          end
        end
        pend    = mem_req && !mem_ready;
        p_addr  = mem_addr;
        p_we    = mem_we;
        p_wdata = mem_wdata;
        if (fill_we != '0 || !repl_web) begin
          check("web_with_fill_we", !repl_web, fill_we != '0);
          check("fill_expected", fill_q.size() > 0, 1'b1);
          if (fill_q.size() > 0) begin
            fe = fill_q.pop_front();
            check("fill_we", fill_we, fe.we);
            check("repl_touch", repl_touch, fe.we);
            check("fill_tag", fill_tag, fe.tag);
            check("fill_data", fill_data, fe.data);
            check("repl_set", repl_set, fe.set);
            check("commit_cycle", cyc, fe.cyc);
          end
        end
        if (miss_done) begin
          check("done_expected", done_q.size() > 0, 1'b1);
          if (done_q.size() > 0) begin
            d = done_q.pop_front();
            check("done_cycle", cyc, d);
          end
          done_cnt++;
        end
      end
    end
  end

  task automatic check_reset(input string pfx);
    check({pfx, "_miss_done"}, miss_done, 1'b0);
    check({pfx, "_mem_req"}, mem_req, 1'b0);
    check({pfx, "_mem_we"}, mem_we, 1'b0);
    check({pfx, "_mem_addr"}, mem_addr, '0);
    check({pfx, "_mem_wdata"}, mem_wdata, '0);
    check({pfx, "_fill_we"}, fill_we, '0);
    check({pfx, "_fill_tag"}, fill_tag, '0);
    check({pfx, "_fill_data"}, fill_data, '0);
    check({pfx, "_repl_web"}, repl_web, 1'b1);
    check({pfx, "_repl_touch"}, repl_touch, '0);
    check({pfx, "_repl_set"}, repl_set, '0);
  endtask

  task automatic run_miss(input logic [SI-1:0] set, input logic [TW-1:0] tag,
                          input logic [W-1:0] valid, input logic [W-1:0] dirty,
                          input logic [W-1:0] cand, input int wbw, input int fw, input bit hold);
    int start;
    int d1;
    int target;
    @(posedge clk);
    #1;
    miss_set        = set;
    miss_tag        = tag;
    way_valid       = valid;
    way_dirty       = dirty;
    evict_candidate = cand;
    wb_wait         = wbw;
    fill_wait       = fw;
    miss_req        = 1'b1;
    @(posedge clk);
    #1;
    start  = cyc;
    d1     = push_expect(start, set, tag);
    target = done_cnt + 1;
    if (hold) begin
      // Held request must start exactly one more miss, in the IDLE cycle after DONE.
      void'(push_expect(d1 + 2, set, tag));
      target++;
    end else begin
      miss_req = 1'b0;
    end
    for (int k = 0; k < 100 && done_cnt < target; k++) begin
      @(negedge clk);
      #1;
    end
    miss_req = 1'b0;
    check("done_count", done_cnt, target);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < W; i++) begin
      way_tags[i*TW +: TW] = TW'(32'h53 + i);
      way_data[i*LW +: LW] = way_line(i);
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b0;

    // All invalid (dirty bits set to show invalid ways never write back).
    run_miss(4'h1, 23'h0abc, 4'b0000, 4'b1111, 4'b0100, 0, 0, 1'b0);
    // All valid and clean.
    run_miss(4'h3, 23'h1234, 4'b1111, 4'b0000, 4'b0010, 0, 0, 1'b0);
    // Dirty way 2 with slow memory on both phases.
    run_miss(4'h7, 23'h2222, 4'b1111, 4'b0100, 4'b0100, 2, 2, 1'b0);
    // Candidate resolution.
    run_miss(4'h5, 23'h0777, 4'b1111, 4'b0000, 4'b0000, 0, 0, 1'b0);
    run_miss(4'h6, 23'h0888, 4'b1111, 4'b0000, 4'b1010, 0, 0, 1'b0);

    // Asynchronous reset while FILL waits on memory.
    @(posedge clk);
    #1;
    miss_set = 4'h9; miss_tag = 23'h3333; way_valid = 4'b1111; way_dirty = 4'b0000;
    evict_candidate = 4'b1000; fill_wait = 8; miss_req = 1'b1;
    @(posedge clk);
    #1;
    miss_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_miss(4'ha, 23'h4444, 4'b1111, 4'b1000, 4'b1000, 1, 0, 1'b0);

    // Request held through a busy miss and across DONE.
    run_miss(4'hb, 23'h5151, 4'b1111, 4'b0000, 4'b0001, 0, 1, 1'b1);

    for (int n = 0; n < 5; n++) begin
      run_miss(SI'($urandom), TW'($urandom), W'($urandom), W'($urandom), W'($urandom),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (5) @(posedge clk);
    check("mem_q_left", mem_q.size(), 0);
    check("fill_q_left", fill_q.size(), 0);
    check("done_q_left", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
